csr_bank: RTL

- Machine-mode CSR storage at the consuming end of the write-back CSR interface.
- Accepts CSR writes (we/waddr/wdata) and the instret increment pulse from the MEM/WB stage.
- Serves combinational CSR reads to the execute stage, maintains the 64-bit cycle and instret counters, and handles trap entry and mret state updates.
- Supplies mtvec, mepc and the interrupt request to the PC/control logic.

---
 rtl/csr_bank_pkg.sv | 27 ++
 rtl/csr_counter64.sv | 26 ++
 rtl/csr_bank.sv | 123 ++++++++++++
 3 files changed

// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg: CSR addresses, field indices, write masks and widths for the machine-mode CSR bank
package csr_bank_pkg;
    localparam int CSR_ADDR_WIDTH = 12;
    localparam int DATA_WIDTH     = 32;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS   = 12'h300;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MISA      = 12'h301;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIE       = 12'h304;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC     = 12'h305;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC      = 12'h341;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE    = 12'h342;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIP       = 12'h344;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MHARTID   = 12'hF14;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIE_MSIE     = 3;
    localparam int MIE_MTIE     = 7;
    localparam int MIE_MEIE     = 11;
    localparam logic [DATA_WIDTH-1:0] MSTATUS_WMASK = 32'h0000_0088;
    localparam logic [DATA_WIDTH-1:0] MSTATUS_MPP   = 32'h0000_1800;
    localparam logic [DATA_WIDTH-1:0] MIE_WMASK     = 32'h0000_0888;
    localparam logic [DATA_WIDTH-1:0] ALIGN4_MASK   = 32'hFFFF_FFFC;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit counter with increment enable and independent lo/hi write ports
module csr_counter64
    import csr_bank_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  inc,
    input  logic                  we_lo,
    input  logic                  we_hi,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [63:0]           value
);
    logic [DATA_WIDTH-1:0] lo, hi;
    logic carry;
    assign carry = inc & (lo == '1);
    assign value = {hi, lo};
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= we_lo ? wdata : lo + DATA_WIDTH'(inc);
            hi <= we_hi ? wdata : hi + DATA_WIDTH'(carry);
        end
    end
endmodule

// File: rtl/csr_bank.sv
// csr_bank: machine-mode CSR storage with counters, trap/mret handling and interrupt request
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter logic [DATA_WIDTH-1:0] HART_ID  = 32'd0,
    parameter logic [DATA_WIDTH-1:0] MISA_VAL = 32'h4000_0100
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      csr_we_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_waddr_i,
    input  logic [DATA_WIDTH-1:0]     csr_wdata_i,
    input  logic                      instret_incr_i,
    input  logic [CSR_ADDR_WIDTH-1:0] csr_raddr_i,
    output logic [DATA_WIDTH-1:0]     csr_rdata_o,
    output logic                      csr_rvalid_o,
    input  logic                      trap_i,
    input  logic [DATA_WIDTH-1:0]     trap_pc_i,
    input  logic [DATA_WIDTH-1:0]     trap_cause_i,
    input  logic                      mret_i,
    input  logic                      irq_sw_i,
    input  logic                      irq_timer_i,
    input  logic                      irq_ext_i,
    output logic [DATA_WIDTH-1:0]     mtvec_o,
    output logic [DATA_WIDTH-1:0]     mepc_o,
    output logic                      int_req_o
);
    logic st_mie, st_mpie;
    logic [DATA_WIDTH-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mip_q;
    logic [DATA_WIDTH-1:0] mstatus_rd, wval, rd_stored;
    logic [63:0] mcycle, minstret;
    logic wr_ok, rd_ok;
    assign mstatus_rd = MSTATUS_MPP | (DATA_WIDTH'(st_mie) << MSTATUS_MIE) | (DATA_WIDTH'(st_mpie) << MSTATUS_MPIE);
    always_comb begin
        wval  = csr_wdata_i;
        wr_ok = 1'b1;
        case (csr_waddr_i)
            CSR_MSTATUS:  wval = (csr_wdata_i & MSTATUS_WMASK) | MSTATUS_MPP;
            CSR_MIE:      wval = csr_wdata_i & MIE_WMASK;
            CSR_MTVEC,
            CSR_MEPC:     wval = csr_wdata_i & ALIGN4_MASK;
            CSR_MSCRATCH, CSR_MCAUSE, CSR_MCYCLE, CSR_MCYCLEH,
            CSR_MINSTRET, CSR_MINSTRETH: wval = csr_wdata_i;
            default:      wr_ok = 1'b0;
        endcase
    end
    always_comb begin
        rd_stored = '0;
        rd_ok     = 1'b1;
        case (csr_raddr_i)
            CSR_MSTATUS:   rd_stored = mstatus_rd;
            CSR_MISA:      rd_stored = MISA_VAL;
            CSR_MIE:       rd_stored = mie_q;
            CSR_MTVEC:     rd_stored = mtvec_q;
            CSR_MSCRATCH:  rd_stored = mscratch_q;
            CSR_MEPC:      rd_stored = mepc_q;
            CSR_MCAUSE:    rd_stored = mcause_q;
            CSR_MIP:       rd_stored = mip_q;
            CSR_MCYCLE:    rd_stored = mcycle[31:0];
            CSR_MCYCLEH:   rd_stored = mcycle[63:32];
            CSR_MINSTRET:  rd_stored = minstret[31:0];
            CSR_MINSTRETH: rd_stored = minstret[63:32];
            CSR_MHARTID:   rd_stored = HART_ID;
            default:       rd_ok = 1'b0;
        endcase
    end
    assign csr_rdata_o  = (csr_we_i && wr_ok && csr_waddr_i == csr_raddr_i) ? wval : rd_stored;
    assign csr_rvalid_o = rd_ok;
    assign int_req_o    = st_mie & |(mie_q & mip_q);
    assign mtvec_o      = mtvec_q;
    assign mepc_o       = mepc_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= '0;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mip_q      <= '0;
        end else begin
            mip_q <= (DATA_WIDTH'(irq_sw_i) << MIE_MSIE) | (DATA_WIDTH'(irq_timer_i) << MIE_MTIE) | (DATA_WIDTH'(irq_ext_i) << MIE_MEIE);
            if (csr_we_i && csr_waddr_i == CSR_MIE) mie_q <= wval;
            if (csr_we_i && csr_waddr_i == CSR_MTVEC) mtvec_q <= wval;
            if (csr_we_i && csr_waddr_i == CSR_MSCRATCH) mscratch_q <= wval;
            if (trap_i) begin
                mepc_q   <= trap_pc_i & ALIGN4_MASK;
                mcause_q <= trap_cause_i;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else begin
                if (mret_i) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (csr_we_i && csr_waddr_i == CSR_MSTATUS) begin
                    st_mie  <= csr_wdata_i[MSTATUS_MIE];
                    st_mpie <= csr_wdata_i[MSTATUS_MPIE];
                end
                if (csr_we_i && csr_waddr_i == CSR_MEPC) mepc_q <= wval;
                if (csr_we_i && csr_waddr_i == CSR_MCAUSE) mcause_q <= wval;
            end
        end
    end
    csr_counter64 u_cycle (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (1'b1),
        .we_lo (csr_we_i && csr_waddr_i == CSR_MCYCLE),
        .we_hi (csr_we_i && csr_waddr_i == CSR_MCYCLEH),
        .wdata (csr_wdata_i),
        .value (mcycle)
    );
    csr_counter64 u_instret (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (instret_incr_i),
        .we_lo (csr_we_i && csr_waddr_i == CSR_MINSTRET),
        .we_hi (csr_we_i && csr_waddr_i == CSR_MINSTRETH),
        .wdata (csr_wdata_i),
        .value (minstret)
    );
endmodule
